// File: rtl/addsub_vector_checker.sv
// addsub_vector_checker: walks all 8 {a,b,cbi} vectors through addsub_halffull and counts mismatches.
// Optional ADDSUB_CHK_FIRST_FAIL_EN adds o_ff_valid/o_ff_info capture of the first failing vector.
module addsub_vector_checker #(
   parameter int SETTLE_CYCLES = 4,
   parameter int ERR_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_mode_addsub,
   input  logic             i_mode_halffull,
   output logic             o_mode_addsub,
   output logic             o_mode_halffull,
   output logic             o_a,
   output logic             o_b,
   output logic             o_cbi,
   input  logic             i_cbo,
   input  logic             i_sd,
   output logic [2:0]       o_vec_idx,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass,
   output logic [ERR_W-1:0] o_err_cnt
`ifdef ADDSUB_CHK_FIRST_FAIL_EN
   ,
   output logic             o_ff_valid,
   output logic [4:0]       o_ff_info
`endif
);
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;
   state_t state, state_nx;
   logic [SW-1:0] scnt;
   logic accept, a, b, c, exp_sd, exp_cbo, mismatch;
   assign accept = i_start && (state == IDLE || state == DONE);
   assign a = o_vec_idx[2];
   assign b = o_vec_idx[1];
   assign c = o_mode_halffull & o_vec_idx[0];
   assign exp_sd = a ^ b ^ c;
   assign exp_cbo = o_mode_addsub ? ((~a & b) | (c & ~(a ^ b))) : ((a & b) | (c & (a ^ b)));
   // X/Z on the DUT outputs must count as a mismatch, hence the case inequality
   assign mismatch = (i_cbo !== exp_cbo) || (i_sd !== exp_sd);
   assign {o_a, o_b, o_cbi} = o_vec_idx;
   assign o_busy = (state == DRIVE) || (state == SETTLE) || (state == CHECK);
   assign o_done = (state == DONE);
   assign o_pass = o_done && (o_err_cnt == '0);
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: state_nx = i_start ? DRIVE : state;
         DRIVE:      state_nx = SETTLE;
         SETTLE:     state_nx = (scnt == '0) ? CHECK : SETTLE;
         CHECK:      state_nx = (o_vec_idx == 3'd7) ? DONE : DRIVE;
         default:    state_nx = IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state           <= IDLE;
         scnt            <= '0;
         o_vec_idx       <= '0;
         o_mode_addsub   <= 1'b0;
         o_mode_halffull <= 1'b0;
         o_err_cnt       <= '0;
`ifdef ADDSUB_CHK_FIRST_FAIL_EN
         o_ff_valid      <= 1'b0;
         o_ff_info       <= '0;
`endif
      end else begin
         state <= state_nx;
         if (accept) begin
            o_mode_addsub   <= i_mode_addsub;
            o_mode_halffull <= i_mode_halffull;
            o_vec_idx       <= '0;
            o_err_cnt       <= '0;
`ifdef ADDSUB_CHK_FIRST_FAIL_EN
            o_ff_valid      <= 1'b0;
            o_ff_info       <= '0;
`endif
         end
         if (state == DRIVE) scnt <= SW'(SETTLE_CYCLES - 1);
         if (state == SETTLE) scnt <= scnt - 1'b1;
         if (state == CHECK) begin
            if (mismatch && o_err_cnt != '1) o_err_cnt <= o_err_cnt + 1'b1;
`ifdef ADDSUB_CHK_FIRST_FAIL_EN
            if (mismatch && !o_ff_valid) begin
               o_ff_valid <= 1'b1;
               o_ff_info  <= {o_vec_idx, i_cbo, i_sd};
            end
`endif
            if (o_vec_idx != 3'd7) o_vec_idx <= o_vec_idx + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_addsub_vector_checker.sv
// tb_addsub_vector_checker: randomized runs against an arithmetic add/sub DUT stand-in with fault injection.
module tb_addsub_vector_checker;
   logic i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0, i_mode_addsub = 1'b0, i_mode_halffull = 1'b0;
   logic o_mode_addsub, o_mode_halffull, o_a, o_b, o_cbi, i_cbo, i_sd, o_busy, o_done, o_pass;
   logic [2:0] o_vec_idx;
   logic [3:0] o_err_cnt;
`ifdef ADDSUB_CHK_FIRST_FAIL_EN
   logic o_ff_valid;
   logic [4:0] o_ff_info;
`endif
   int checks = 0, failures = 0;
   int fault = 0;
   logic [7:0] fmask = '0;
   logic [1:0] g;
   always #5 i_clk = ~i_clk;
   addsub_vector_checker dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
      .i_mode_addsub(i_mode_addsub), .i_mode_halffull(i_mode_halffull),
      .o_mode_addsub(o_mode_addsub), .o_mode_halffull(o_mode_halffull),
      .o_a(o_a), .o_b(o_b), .o_cbi(o_cbi), .i_cbo(i_cbo), .i_sd(i_sd),
      .o_vec_idx(o_vec_idx), .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
      .o_err_cnt(o_err_cnt)
`ifdef ADDSUB_CHK_FIRST_FAIL_EN
      , .o_ff_valid(o_ff_valid), .o_ff_info(o_ff_info)
`endif
   );
   function automatic logic [1:0] good(input logic as, input logic hf, input logic a, input logic b, input logic ci);
      int c, r;
      c = hf ? int'(ci) : 0;
      r = as ? int'(a) - int'(b) - c : int'(a) + int'(b) + c;
      return {(as ? (r < 0) : (r > 1)), r[0]};
   endfunction
   function automatic logic [1:0] faulty(input logic [1:0] gv, input int fm, input logic [7:0] mk, input logic [2:0] v);
      return (fm == 1) ? {gv[1], 1'b0} : (fm == 2) ? {gv[1] ^ mk[v], gv[0]} : gv;
   endfunction
   assign g = good(o_mode_addsub, o_mode_halffull, o_a, o_b, o_cbi);
   assign {i_cbo, i_sd} = faulty(g, fault, fmask, o_vec_idx);
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic run(input logic as, input logic hf, input int fm, input logic [7:0] mk, input bit repulse, input bit abort);
      int n, busy_n, exp_err;
      bit vec_ok, has_ff;
      logic [4:0] exp_ff;
      logic [2:0] v;
      logic [1:0] gv, fv;
      exp_err = 0;
      has_ff = 0;
      exp_ff = '0;
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         gv = good(as, hf, v[2], v[1], v[0]);
         fv = faulty(gv, fm, mk, v);
         if (fv != gv) begin
            exp_err++;
            if (!has_ff) exp_ff = {v, fv};
            has_ff = 1;
         end
      end
      fault = fm;
      fmask = mk;
      @(negedge i_clk);
      i_start = 1'b1;
      i_mode_addsub = as;
      i_mode_halffull = hf;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      i_mode_addsub = ~as;
      i_mode_halffull = ~hf;
      n = 0;
      busy_n = 0;
      vec_ok = 1;
      while (!o_done && n < 200) begin
         if (o_busy) busy_n++;
         if ({o_a, o_b, o_cbi} !== o_vec_idx) vec_ok = 0;
         i_start = repulse && n == 10;
         if (abort && n == 20) begin
            i_rst_n = 1'b0;
            @(posedge i_clk);
            #1;
            i_rst_n = 1'b1;
            check("abort_busy", 32'(o_busy), 0);
            check("abort_done", 32'(o_done), 0);
            check("abort_err", 32'(o_err_cnt), 0);
            check("abort_idx", 32'(o_vec_idx), 0);
            return;
         end
         @(posedge i_clk);
         #1;
         n++;
      end
      i_start = 1'b0;
      check("done_latency", n, 48);
      check("busy_cycles", busy_n, 48);
      check("vec_outputs", 32'(vec_ok), 1);
      check("done", 32'(o_done), 1);
      check("busy_at_done", 32'(o_busy), 0);
      check("err_cnt", 32'(o_err_cnt), exp_err);
      check("pass", 32'(o_pass), 32'(exp_err == 0));
      check("mode_as", 32'(o_mode_addsub), 32'(as));
      check("mode_hf", 32'(o_mode_halffull), 32'(hf));
`ifdef ADDSUB_CHK_FIRST_FAIL_EN
      check("ff_valid", 32'(o_ff_valid), 32'(has_ff));
      check("ff_info", 32'(o_ff_info), 32'(exp_ff));
`endif
      repeat (2) @(posedge i_clk);
      #1;
      check("done_hold", 32'(o_done), 1);
      check("err_hold", 32'(o_err_cnt), exp_err);
   endtask
   initial begin
      repeat (3) @(posedge i_clk);
      #1;
      check("rst_busy", 32'(o_busy), 0);
      check("rst_done", 32'(o_done), 0);
      check("rst_pass", 32'(o_pass), 0);
      check("rst_err", 32'(o_err_cnt), 0);
      check("rst_idx", 32'(o_vec_idx), 0);
      check("rst_abc", 32'({o_a, o_b, o_cbi}), 0);
      check("rst_modes", 32'({o_mode_addsub, o_mode_halffull}), 0);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      check("idle_no_start", 32'(o_busy), 0);
      run(1'b0, 1'b1, 0, 8'h00, 0, 0);
      run(1'b1, 1'b0, 0, 8'h00, 0, 0);
      run(1'b0, 1'b1, 1, 8'h00, 0, 0);
      run(1'b1, 1'b1, 0, 8'h00, 1, 0);
      run(1'b0, 1'b0, 0, 8'h00, 0, 1);
      run(1'b1, 1'b1, 0, 8'h00, 0, 0);
      run(1'b1, 1'b1, 1, 8'h00, 0, 0);
      for (int k = 0; k < 8; k++)
         run(1'($urandom), 1'($urandom), 2 * int'($urandom_range(0, 1)), 8'($urandom), 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
